// File: rtl/regfile_pkg.sv
// Purpose : shared register-file constants, read-sequencer state encoding and helpers.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_REGS_DEF   = 32;

  // Register index that reads as constant zero when the zero-register option is on.
  localparam int ZERO_REG_ADDR  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE_A = 3'd1,
    ST_GAP     = 3'd2,
    ST_DRIVE_B = 3'd3,
    ST_RESP    = 3'd4
  } rd_state_e;

  // Width of a down-counter that must hold the value 'settle'.
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/regfile_bus_reader_if.sv
// Purpose : request / register-file bus / response bundle of the operand read sequencer.
// Latency : n/a (wiring only).
// Backpr. : req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Ports   : slave = sequencer side, master = decode stage + register file side.
interface regfile_bus_reader_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS   = NUM_REGS_DEF
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [NUM_REGS-1:0]   bus_enable;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  rsp_err;

  modport slave (
    input  req_valid, rs1_addr, rs2_addr, bus_data, rsp_ready,
    output req_ready, bus_enable, rsp_valid, rs1_data, rs2_data, rsp_err
  );

  modport master (
    output req_valid, rs1_addr, rs2_addr, bus_data, rsp_ready,
    input  req_ready, bus_enable, rsp_valid, rs1_data, rs2_data, rsp_err
  );
endinterface

// File: rtl/regfile_bus_reader_onehot_decoder.sv
// Purpose : register address -> one-hot driver enable; all-zero when disabled or out of range.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_addr register index, i_en phase enable, o_onehot NUM_REGS driver enables.
module onehot_decoder #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_en,
  output logic [NUM_REGS-1:0]   o_onehot
);

  // Only indices below NUM_REGS have a bit, so an out-of-range address matches nothing.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_onehot[i] = i_en && (i_addr == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/regfile_bus_reader.sv
// Purpose : fetches rs1 then rs2 over the shared register-file bus, one driver enabled at a time.
// Latency : rsp_valid 2*SETTLE_CYCLES+3 cycles after request accept, independent of addresses.
// Backpr. : one request in flight; req_ready low until response taken plus one idle cycle.
// Ports   : i_clk, i_reset_n (async active-low), io_bus (slave side of regfile_bus_reader_if).
module regfile_bus_reader
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int NUM_REGS      = NUM_REGS_DEF,
  parameter int SETTLE_CYCLES = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  regfile_bus_reader_if.slave   io_bus
);

  localparam int                CNT_W       = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(SETTLE_CYCLES);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_LIM = (ADDR_WIDTH + 1)'(NUM_REGS);

  rd_state_e             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;

  logic                  w_drive_a;
  logic                  w_drive_b;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_is_zero;
  logic                  w_oor;
  logic                  w_dec_en;
  logic                  w_phase_done;
  logic [DATA_WIDTH-1:0] w_sample;

  assign w_drive_a    = (r_state == ST_DRIVE_A);
  assign w_drive_b    = (r_state == ST_DRIVE_B);
  assign w_addr       = w_drive_b ? r_addr_b : r_addr_a;
  assign w_is_zero    = (ZERO_REG != 0) && (w_addr == ADDR_WIDTH'(ZERO_REG_ADDR));
  assign w_oor        = ({1'b0, w_addr} >= NUM_REGS_LIM);
  assign w_dec_en     = (w_drive_a || w_drive_b) && !w_is_zero;
  assign w_phase_done = (r_cnt == '0);
  // Nothing drives the bus for the zero register or a missing register: force zero.
  assign w_sample     = (w_is_zero || w_oor) ? '0 : io_bus.bus_data;

  // Enables come straight from registered state and address, so the async reset clears
  // them without waiting for a clock edge.
  onehot_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_dec (
    .i_addr   (w_addr),
    .i_en     (w_dec_en),
    .o_onehot (io_bus.bus_enable)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // req_ready rises one cycle after entering IDLE, giving the dead cycle after
          // a response and the first ready cycle after reset.
          if (r_req_ready && io_bus.req_valid) begin
            r_addr_a    <= io_bus.rs1_addr;
            r_addr_b    <= io_bus.rs2_addr;
            r_rsp_err   <= 1'b0;
            r_cnt       <= CNT_LOAD;
            r_req_ready <= 1'b0;
            r_state     <= ST_DRIVE_A;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_DRIVE_A: begin
          // Capture on the last edge of the phase while the driver is still enabled.
          if (w_phase_done) begin
            r_rs1_data <= w_sample;
            r_rsp_err  <= r_rsp_err | w_oor;
            r_state    <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          r_cnt   <= CNT_LOAD;
          r_state <= ST_DRIVE_B;
        end
        ST_DRIVE_B: begin
          if (w_phase_done) begin
            r_rs2_data  <= w_sample;
            r_rsp_err   <= r_rsp_err | w_oor;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.req_ready = r_req_ready;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_err   = r_rsp_err;
  assign io_bus.rs1_data  = r_rs1_data;
  assign io_bus.rs2_data  = r_rs2_data;

endmodule
